alarma_multicanal: RTL and testbench

ALARMA_MULTICANAL -- requirements
Module: alarma_multicanal

---
 rtl/alarma_multicanal.sv | 146 ++++++++++++++
 tb/tb_alarma_multicanal.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarma_multicanal.sv
// Multi-channel alarm clock: BCD time compare per channel, edge-triggered pending
// requests served lowest-index first. Snooze support is built only when ALARMA_SNOOZE_EN is defined.
module alarma_multicanal #(
    parameter int N_ALARMAS    = 4,
    parameter int DURACION_SEG = 60,
    parameter int SNOOZE_SEG   = 300,
    localparam int CW          = (N_ALARMAS > 1) ? $clog2(N_ALARMAS) : 1
) (
    input  logic                   reloj1,
    input  logic                   apagado,
    input  logic [15:0]            hora,
    input  logic [16*N_ALARMAS-1:0] alarmas,
    input  logic [N_ALARMAS-1:0]   habilitar,
    input  logic                   tick_seg,
    input  logic                   detener,
    input  logic                   posponer,
    output logic                   alam,
    output logic [CW-1:0]          canal,
    output logic                   pospuesta
);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        SONANDO   = 2'd1,
        POSPUESTA = 2'd2
    } estado_t;

    localparam logic [9:0] DUR_C = 10'(DURACION_SEG);
    localparam logic [9:0] SNZ_C = 10'(SNOOZE_SEG);

    estado_t                estado_q, estado_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [CW-1:0]          canal_q, canal_d;
    logic [N_ALARMAS-1:0]   pend_q, pend_d;
    logic [N_ALARMAS-1:0]   match_prev_q, match_prev_d;
    logic                   alam_q, alam_d;
    logic                   posp_q, posp_d;

    logic [N_ALARMAS-1:0]   match;
    logic [N_ALARMAS-1:0]   trig;
    logic [N_ALARMAS-1:0]   pend_all;
    logic [N_ALARMAS-1:0]   sel_oh;
    logic [CW-1:0]          sel;
    logic                   snooze_req;

`ifdef ALARMA_SNOOZE_EN
    assign snooze_req = posponer;
`else
    logic unused_posponer;
    assign unused_posponer = posponer;
    assign snooze_req      = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < N_ALARMAS; i++) begin
            match[i] = (alarmas[16*i +: 16] == hora);
        end
        match_prev_d = match;
        trig         = habilitar & match & ~match_prev_q;
        // Disabling a channel also withdraws any request it already queued.
        pend_all     = (pend_q | trig) & habilitar;
        sel_oh       = pend_all & (~pend_all + 1'b1);
        sel          = '0;
        for (int i = N_ALARMAS - 1; i >= 0; i--) begin
            if (pend_all[i]) sel = CW'(i);
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        canal_d  = canal_q;
        pend_d   = pend_all;
        case (estado_q)
            REPOSO: begin
                if (|pend_all) begin
                    estado_d = SONANDO;
                    canal_d  = sel;
                    cnt_d    = DUR_C;
                    pend_d   = pend_all & ~sel_oh;
                end
            end
            SONANDO: begin
                if (detener) begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end else if (snooze_req) begin
                    estado_d = POSPUESTA;
                    cnt_d    = SNZ_C;
                end else if (tick_seg) begin
                    if (cnt_q <= 10'd1) begin
                        estado_d = REPOSO;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
            end
            POSPUESTA: begin
                if (detener) begin
                    estado_d = REPOSO;
                    cnt_d    = '0;
                end else if (tick_seg) begin
                    if (cnt_q <= 10'd1) begin
                        estado_d = SONANDO;
                        cnt_d    = DUR_C;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
            end
            default: begin
                estado_d = REPOSO;
                cnt_d    = '0;
            end
        endcase
        alam_d = (estado_d == SONANDO);
        posp_d = (estado_d == POSPUESTA);
    end

    // match_prev resets to ones so a time already matching at release is not an edge.
    always_ff @(posedge reloj1 or posedge apagado) begin
        if (apagado) begin
            estado_q     <= REPOSO;
            cnt_q        <= '0;
            canal_q      <= '0;
            pend_q       <= '0;
            match_prev_q <= '1;
            alam_q       <= 1'b0;
            posp_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            canal_q      <= canal_d;
            pend_q       <= pend_d;
            match_prev_q <= match_prev_d;
            alam_q       <= alam_d;
            posp_q       <= posp_d;
        end
    end

    assign alam      = alam_q;
    assign canal     = canal_q;
    assign pospuesta = posp_q;

endmodule

// File: tb/tb_alarma_multicanal.sv
// Bench for alarma_multicanal: directed scenarios plus random traffic, scored against
// a behavioural model; snooze expectations follow ALARMA_SNOOZE_EN.
module tb_alarma_multicanal;

    localparam int N   = 4;
    localparam int DUR = 3;
    localparam int SNZ = 2;
`ifdef ALARMA_SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic        reloj1 = 1'b0;
    logic        apagado = 1'b1;
    logic [15:0] hora = 16'h0000;
    logic [63:0] alarmas = 64'h0;
    logic [3:0]  habilitar = 4'h0;
    logic        tick_seg = 1'b0;
    logic        detener = 1'b0;
    logic        posponer = 1'b0;
    logic        alam;
    logic [1:0]  canal;
    logic        pospuesta;

    alarma_multicanal #(
        .N_ALARMAS   (N),
        .DURACION_SEG(DUR),
        .SNOOZE_SEG  (SNZ)
    ) dut (
        .reloj1   (reloj1),
        .apagado  (apagado),
        .hora     (hora),
        .alarmas  (alarmas),
        .habilitar(habilitar),
        .tick_seg (tick_seg),
        .detener  (detener),
        .posponer (posponer),
        .alam     (alam),
        .canal    (canal),
        .pospuesta(pospuesta)
    );

    always #5 reloj1 = ~reloj1;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_e;

    // Model: mode 0 idle, 1 ringing, 2 snoozed; requests kept as a flag per channel.
    int m_mode;
    int m_ch;
    int m_rem;
    bit m_pend[N];
    bit m_prev[N];

    task automatic model_reset();
        m_mode = 0;
        m_ch   = 0;
        m_rem  = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b1;
        end
    endtask

    task automatic model_step(input logic [15:0] h, input logic [3:0] en,
                              input bit t, input bit d, input bit p);
        bit mt;
        int first;
        for (int i = 0; i < N; i++) begin
            mt = (alarmas[16*i +: 16] == h);
            if (en[i] && mt && !m_prev[i]) m_pend[i] = 1'b1;
            if (!en[i]) m_pend[i] = 1'b0;
            m_prev[i] = mt;
        end
        if (m_mode == 0) begin
            first = -1;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) first = i;
            if (first >= 0) begin
                m_mode = 1;
                m_ch   = first;
                m_rem  = DUR;
                m_pend[first] = 1'b0;
            end
        end else if (d) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (SNOOZE_ON && p) begin
                m_mode = 2;
                m_rem  = SNZ;
            end else if (t) begin
                if (m_rem == 1) m_mode = 0;
                else m_rem = m_rem - 1;
            end
        end else if (t) begin
            if (m_rem == 1) begin
                m_mode = 1;
                m_rem  = DUR;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    // Drives one cycle of inputs and queues the outputs expected after the next edge.
    task automatic cyc(input logic [15:0] h, input logic [3:0] en,
                       input bit t, input bit d, input bit p);
        hora      = h;
        habilitar = en;
        tick_seg  = t;
        detener   = d;
        posponer  = p;
        model_step(h, en, t, d, p);
        exp_q.push_back({m_mode == 1, m_mode == 2, 2'(m_ch)});
        @(negedge reloj1);
    endtask

    task automatic idle(input logic [15:0] h, input logic [3:0] en, input int n);
        for (int k = 0; k < n; k++) cyc(h, en, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    always @(posedge reloj1) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({alam, pospuesta, canal} !== mon_e) begin
                errors++;
                $display("FAIL outputs at %0t: got alam=%b pospuesta=%b canal=%0d, expected alam=%b pospuesta=%b canal=%0d",
                         $time, alam, pospuesta, canal, mon_e[3], mon_e[2], mon_e[1:0]);
            end
        end
    end

    initial begin
        logic [15:0] cur_h;
        logic [3:0]  cur_en;
        logic [15:0] horas[5];
        horas = '{16'h1200, 16'h0600, 16'h0730, 16'h0000, 16'h0601};
        alarmas = {16'h0600, 16'h0730, 16'h0600, 16'h1200};
        model_reset();
        repeat (3) @(negedge reloj1);
        chk("reset_outputs", {alam, pospuesta, canal}, 4'b0000);
        apagado = 1'b0;

        // Basic ring on channel 2 with auto-off after three seconds.
        idle(16'h0729, 4'b0100, 2);
        idle(16'h0730, 4'b0100, 2);
        for (int k = 0; k < 3; k++) begin
            cyc(16'h0730, 4'b0100, 1'b1, 1'b0, 1'b0);
            idle(16'h0730, 4'b0100, 1);
        end
        idle(16'h0731, 4'b0100, 2);

        // Stop with the match still present must not retrigger.
        idle(16'h1159, 4'b0001, 1);
        idle(16'h1200, 4'b0001, 2);
        cyc(16'h1200, 4'b0001, 1'b0, 1'b1, 1'b0);
        idle(16'h1200, 4'b0001, 4);

        // Snooze, wake after two seconds, then stop and snooze together.
        idle(16'h0559, 4'b0010, 1);
        idle(16'h0600, 4'b0010, 2);
        cyc(16'h0600, 4'b0010, 1'b0, 1'b0, 1'b1);
        idle(16'h0600, 4'b0010, 1);
        cyc(16'h0600, 4'b0010, 1'b1, 1'b0, 1'b0);
        cyc(16'h0600, 4'b0010, 1'b1, 1'b0, 1'b0);
        idle(16'h0600, 4'b0010, 1);
        cyc(16'h0600, 4'b0010, 1'b0, 1'b1, 1'b1);
        idle(16'h0600, 4'b0010, 2);

        // Simultaneous triggers on channels 1 and 3.
        idle(16'h0559, 4'b1010, 1);
        idle(16'h0600, 4'b1010, 2);
        cyc(16'h0600, 4'b1010, 1'b0, 1'b1, 1'b0);
        idle(16'h0600, 4'b1010, 2);
        cyc(16'h0600, 4'b1010, 1'b0, 1'b1, 1'b0);
        idle(16'h0600, 4'b1010, 2);

        // Asynchronous reset while ringing, match held through release.
        idle(16'h0729, 4'b0100, 1);
        idle(16'h0730, 4'b0100, 2);
        apagado = 1'b1;
        #1;
        chk("async_reset", {alam, pospuesta, canal}, 4'b0000);
        repeat (2) @(negedge reloj1);
        chk("reset_held", {alam, pospuesta, canal}, 4'b0000);
        apagado = 1'b0;
        model_reset();
        idle(16'h0730, 4'b0100, 5);

        // Disabled channel 0 never rings.
        idle(16'h1159, 4'b0000, 1);
        idle(16'h1200, 4'b0000, 4);

        // Random traffic.
        cur_h  = 16'h0000;
        cur_en = 4'b1111;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) cur_h = horas[$urandom_range(0, 4)];
            if ($urandom_range(0, 19) == 0) cur_en = 4'($urandom_range(0, 15));
            cyc(cur_h, cur_en, $urandom_range(0, 2) == 0,
                $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0);
        end
        idle(cur_h, cur_en, 2);
        @(posedge reloj1);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
